xdma_req_sequencer: RTL and testbench

Command-driven request sequencer sitting directly upstream of the DMA data converter in the xDMA path. It accepts one transfer descriptor at a time: mode, SRAM start address and beat count. For memory-to-buffer modes it pulls DWIDTH-bit beats from an inbound stream and issues write requests on the GIF-style request port. For buffer-to-memory modes it issues read requests and buffers the returned DW_IOB-bit data in a small FIFO toward an outbound stream.

---
 rtl/xdma_pkg.sv | 40 ++++
 rtl/xdma_rd_fifo.sv | 64 ++++++
 rtl/xdma_req_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_xdma_req_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_pkg.sv
// xdma_pkg
// Shared definitions for the xDMA request path:
//   - dma_mode encodings (4-bit) seen by the converter
//   - is_write_mode / is_read_mode mode classifiers
//   - seq_state_e: request sequencer state encoding (also exported on dbg_state)
package xdma_pkg;

    localparam logic [3:0] M2IOB0  = 4'd1;
    localparam logic [3:0] M2IOB1  = 4'd2;
    localparam logic [3:0] IOB2M0  = 4'd3;
    localparam logic [3:0] IOB2M1  = 4'd4;
    localparam logic [3:0] M2XB0   = 4'd5;
    localparam logic [3:0] M2XB1   = 4'd6;
    localparam logic [3:0] M2XB2   = 4'd7;
    localparam logic [3:0] M2XB3   = 4'd8;
    localparam logic [3:0] M2LSTMB = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    function automatic logic is_write_mode(input logic [3:0] mode);
        case (mode)
            M2IOB0, M2IOB1, M2XB0, M2XB1, M2XB2, M2XB3, M2LSTMB: is_write_mode = 1'b1;
            default:                                             is_write_mode = 1'b0;
        endcase
    endfunction

    function automatic logic is_read_mode(input logic [3:0] mode);
        case (mode)
            IOB2M0, IOB2M1: is_read_mode = 1'b1;
            default:        is_read_mode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/xdma_rd_fifo.sv
// xdma_rd_fifo
// Synchronous DEPTH x WIDTH FIFO buffering read-return data.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_wdata  write side; a push while full is taken only with a pop
//   i_pop            read side; ignored when empty
//   o_rdata          head entry (valid while !o_empty)
//   o_full, o_empty, o_count  occupancy
module xdma_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    // Full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/xdma_req_sequencer.sv
// xdma_req_sequencer
// Takes one transfer descriptor at a time and drives GIF-style requests
// toward the DMA data converter. Write modes move beats from the in stream
// onto mwrite/mdata; read modes issue mread and buffer returned sdata in a
// RD_DEPTH-entry FIFO toward the out stream.
// Ports:
//   xclk, xreset                 clock, synchronous active-high reset
//   cmd_*                        descriptor handshake (mode, addr, len)
//   in_*                         write-data stream (sink)
//   out_*                        read-data stream (source)
//   dma_mode, maddr_sram_start   registered descriptor fields
//   maddr, mread, mwrite, mdata, mwstrb, mready   request side
//   saccept, svalid, sdata       converter accept / response
//   busy, done, err_mode         status; done and err_mode are 1-cycle pulses
//   perf_beats, perf_stall       counters, built only with XDMA_SEQ_PERF_EN,
//                                tied to 0 otherwise
//   dbg_state, dbg_fifo_count    FSM state and read FIFO occupancy
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; a source holds valid and payload steady until that cycle, and ready
// may depend combinationally on valid only through the documented terms.
module xdma_req_sequencer
    import xdma_pkg::*;
#(
    parameter int DWIDTH   = 128,
    parameter int DW_IOB   = 256,
    parameter int LENW     = 16,
    parameter int RD_DEPTH = 4
) (
    input  logic                      xclk,
    input  logic                      xreset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [3:0]                cmd_mode,
    input  logic [31:0]               cmd_addr,
    input  logic [LENW-1:0]           cmd_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DWIDTH-1:0]         in_data,
    input  logic [DWIDTH/8-1:0]       in_strb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW_IOB-1:0]         out_data,
    output logic [3:0]                dma_mode,
    output logic [31:0]               maddr_sram_start,
    output logic [31:0]               maddr,
    output logic                      mread,
    output logic                      mwrite,
    output logic [DWIDTH-1:0]         mdata,
    output logic [DWIDTH/8-1:0]       mwstrb,
    output logic                      mready,
    input  logic                      saccept,
    input  logic                      svalid,
    input  logic [DW_IOB-1:0]         sdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err_mode,
    output logic [31:0]               perf_beats,
    output logic [31:0]               perf_stall,
    output logic [2:0]                dbg_state,
    output logic [$clog2(RD_DEPTH):0] dbg_fifo_count
);
    localparam int SW = DWIDTH / 8;
    localparam int CW = $clog2(RD_DEPTH) + 1;

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [3:0]        r_dma_mode;
    logic [31:0]       r_sram_start;
    logic [31:0]       r_maddr;
    logic [LENW-1:0]   r_remaining;
    logic              r_hold_valid;
    logic [DWIDTH-1:0] r_hold_data;
    logic [SW-1:0]     r_hold_strb;
    logic              r_err_mode;

    logic              w_cmd_ready, w_cmd_fire, w_mode_wr, w_mode_rd;
    logic              w_in_ready, w_in_fire, w_mwrite, w_mread, w_mready;
    logic              w_wr_beat, w_rd_beat, w_pop;
    logic              w_fifo_full, w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [DW_IOB-1:0] w_fifo_rdata;

    assign w_mode_wr   = is_write_mode(cmd_mode);
    assign w_mode_rd   = is_read_mode(cmd_mode);
    assign w_cmd_ready = (r_state == ST_IDLE) && !xreset;
    assign w_cmd_fire  = cmd_valid && w_cmd_ready;

    assign w_mwrite  = (r_state == ST_WR) && r_hold_valid;
    assign w_wr_beat = w_mwrite && saccept;   // mready is 1 throughout WR
    // Refill only while beats remain that the holding register does not
    // already cover; refilling on the completing cycle keeps 1 beat/cycle.
    assign w_in_ready = (r_state == ST_WR)
                     && (r_remaining > {{(LENW-1){1'b0}}, r_hold_valid})
                     && (!r_hold_valid || w_wr_beat);
    assign w_in_fire  = in_valid && w_in_ready;

    assign w_mread   = (r_state == ST_RD) && (r_remaining != '0) && !w_fifo_full;
    assign w_mready  = (r_state == ST_WR) || ((r_state == ST_RD) && !w_fifo_full);
    assign w_rd_beat = w_mread && saccept && svalid;
    assign w_pop     = !w_fifo_empty && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    if (w_mode_wr)      w_state_nxt = (cmd_len == '0) ? ST_DONE : ST_WR;
                    else if (w_mode_rd) w_state_nxt = (cmd_len == '0) ? ST_DONE : ST_RD;
                    else                w_state_nxt = ST_IDLE;
                end
            end
            ST_WR:    if (w_wr_beat && (r_remaining == LENW'(1))) w_state_nxt = ST_DONE;
            ST_RD:    if (w_rd_beat && (r_remaining == LENW'(1))) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_fifo_empty) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge xclk) begin
        if (xreset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge xclk) begin
        if (xreset) begin
            r_dma_mode   <= '0;
            r_sram_start <= '0;
            r_maddr      <= '0;
            r_remaining  <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_strb  <= '0;
            r_err_mode   <= 1'b0;
        end else begin
            r_err_mode <= w_cmd_fire && !w_mode_wr && !w_mode_rd;
            if (w_cmd_fire && (w_mode_wr || w_mode_rd)) begin
                r_dma_mode   <= cmd_mode;
                r_sram_start <= cmd_addr;
                r_maddr      <= cmd_addr;
                r_remaining  <= cmd_len;
            end else if (w_wr_beat || w_rd_beat) begin
                r_maddr     <= r_maddr + 32'd1;   // wraps modulo 2^32
                r_remaining <= r_remaining - LENW'(1);
            end
            if (w_in_fire) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= in_data;
                r_hold_strb  <= in_strb;
            end else if (w_wr_beat) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    xdma_rd_fifo #(
        .DEPTH (RD_DEPTH),
        .WIDTH (DW_IOB)
    ) u_rd_fifo (
        .i_clk   (xclk),
        .i_rst   (xreset),
        .i_push  (w_rd_beat),
        .i_wdata (sdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef XDMA_SEQ_PERF_EN
    logic [31:0] r_perf_beats;
    logic [31:0] r_perf_stall;

    always_ff @(posedge xclk) begin
        if (xreset || w_cmd_fire) begin
            r_perf_beats <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((w_wr_beat || w_rd_beat) && (r_perf_beats != '1))
                r_perf_beats <= r_perf_beats + 32'd1;
            if ((w_mread || w_mwrite) && !saccept && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_beats = r_perf_beats;
    assign perf_stall = r_perf_stall;
`else
    assign perf_beats = '0;
    assign perf_stall = '0;
`endif

    assign cmd_ready        = w_cmd_ready;
    assign in_ready         = w_in_ready;
    assign out_valid        = !w_fifo_empty;
    assign out_data         = w_fifo_rdata;
    assign dma_mode         = r_dma_mode;
    assign maddr_sram_start = r_sram_start;
    assign maddr            = r_maddr;
    assign mread            = w_mread;
    assign mwrite           = w_mwrite;
    assign mdata            = r_hold_data;
    assign mwstrb           = r_hold_strb;
    assign mready           = w_mready;
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);
    assign err_mode         = r_err_mode;
    assign dbg_state        = r_state;
    assign dbg_fifo_count   = w_fifo_count;

endmodule

// File: tb/tb_xdma_req_sequencer.sv
module tb_xdma_req_sequencer;
    localparam int DWIDTH   = 128;
    localparam int DW_IOB   = 256;
    localparam int LENW     = 16;
    localparam int RD_DEPTH = 4;

    logic                xclk = 1'b0;
    logic                xreset;
    logic                cmd_valid, cmd_ready;
    logic [3:0]          cmd_mode;
    logic [31:0]         cmd_addr;
    logic [LENW-1:0]     cmd_len;
    logic                in_valid, in_ready;
    logic [DWIDTH-1:0]   in_data;
    logic [DWIDTH/8-1:0] in_strb;
    logic                out_valid, out_ready;
    logic [DW_IOB-1:0]   out_data;
    logic [3:0]          dma_mode;
    logic [31:0]         maddr_sram_start, maddr;
    logic                mread, mwrite, mready;
    logic [DWIDTH-1:0]   mdata;
    logic [DWIDTH/8-1:0] mwstrb;
    logic                saccept, svalid;
    logic [DW_IOB-1:0]   sdata;
    logic                busy, done, err_mode;
    logic [31:0]         perf_beats, perf_stall;
    logic [2:0]          dbg_state;
    logic [2:0]          dbg_fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW_IOB-1:0] exp_q[$];

    always #5 xclk = ~xclk;

    xdma_req_sequencer #(
        .DWIDTH(DWIDTH), .DW_IOB(DW_IOB), .LENW(LENW), .RD_DEPTH(RD_DEPTH)
    ) dut (
        .xclk(xclk), .xreset(xreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_strb(in_strb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dma_mode(dma_mode), .maddr_sram_start(maddr_sram_start), .maddr(maddr),
        .mread(mread), .mwrite(mwrite), .mdata(mdata), .mwstrb(mwstrb), .mready(mready),
        .saccept(saccept), .svalid(svalid), .sdata(sdata),
        .busy(busy), .done(done), .err_mode(err_mode),
        .perf_beats(perf_beats), .perf_stall(perf_stall),
        .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
    );

    function automatic logic [DWIDTH-1:0] wd(input int i);
        return {4{32'hA5A5_0000 + 32'(i)}};
    endfunction

    function automatic logic [DW_IOB-1:0] rd(input int i);
        return {8{32'h5A00_0000 + 32'(i)}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge xclk);
        #1;
    endtask

    task automatic mid();
        @(negedge xclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got;
        logic seen_done;

        xreset = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_addr = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; in_strb = '0; out_ready = 1'b0;
        saccept = 1'b0; svalid = 1'b0; sdata = '0;

        // ---------------- reset ----------------
        next_cycle();
        mid();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mwrite", mwrite, 0);
        chk("rst_mread", mread, 0);
        chk("rst_dma_mode", dma_mode, 0);
        chk("rst_maddr", maddr, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, 0);
        next_cycle();
        xreset = 1'b0;
        mid();
        chk("idle_cmd_ready", cmd_ready, 1);

        // ---------------- test 1: mode 1, 4 back-to-back beats ----------------
        next_cycle();
        cmd_valid = 1'b1; cmd_mode = 4'd1; cmd_addr = 32'h100; cmd_len = 16'd4; saccept = 1'b1;
        mid();
        chk("t1_cmd_ready", cmd_ready, 1);
        next_cycle();
        cmd_valid = 1'b0; in_valid = 1'b1; in_data = wd(0); in_strb = 16'hFFFF;
        mid();
        chk("t1_dma_mode", dma_mode, 1);
        chk("t1_sram_start", maddr_sram_start, 32'h100);
        chk("t1_maddr0", maddr, 32'h100);
        chk("t1_in_ready0", in_ready, 1);
        chk("t1_no_mwrite", mwrite, 0);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i < 3) in_data = wd(i + 1);
            else       in_valid = 1'b0;
            mid();
            chk("t1_mwrite", mwrite, 1);
            chk("t1_maddr", maddr, 32'h100 + 32'(i));
            chk("t1_mdata", mdata, wd(i));
            chk("t1_in_ready", in_ready, (i < 3));
            chk("t1_no_early_done", done, 0);
        end
        next_cycle();
        mid();
        chk("t1_done", done, 1);
        chk("t1_mwrite_off", mwrite, 0);
        chk("t1_maddr_end", maddr, 32'h104);
`ifdef XDMA_SEQ_PERF_EN
        chk("t1_perf_beats", perf_beats, 4);
        chk("t1_perf_stall", perf_stall, 0);
`endif
        next_cycle();
        mid();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_ready", cmd_ready, 1);
        chk("t1_idle_busy", busy, 0);

        // ---------------- test 2: mode 5, stall on beat 2 ----------------
        next_cycle();
        cmd_valid = 1'b1; cmd_mode = 4'd5; cmd_addr = 32'h200; cmd_len = 16'd3; saccept = 1'b1;
        mid();
        chk("t2_cmd_ready", cmd_ready, 1);
        next_cycle();
        cmd_valid = 1'b0; in_valid = 1'b1; in_data = wd(16); in_strb = 16'hFFFF;
        mid();
        chk("t2_in_ready", in_ready, 1);
        next_cycle();
        in_data = wd(17); in_strb = 16'h0000;
        mid();
        chk("t2_maddr0", maddr, 32'h200);
        chk("t2_mdata0", mdata, wd(16));
        chk("t2_mwstrb0", mwstrb, 16'hFFFF);
        for (int s = 0; s < 2; s++) begin
            next_cycle();
            saccept = 1'b0; in_data = wd(18); in_strb = 16'h0F0F;
            mid();
            chk("t2_stall_mwrite", mwrite, 1);
            chk("t2_stall_maddr", maddr, 32'h201);
            chk("t2_stall_mdata", mdata, wd(17));
            chk("t2_stall_mwstrb", mwstrb, 16'h0000);
            chk("t2_stall_in_ready", in_ready, 0);
        end
        next_cycle();
        saccept = 1'b1;
        mid();
        chk("t2_resume_maddr", maddr, 32'h201);
        chk("t2_resume_in_ready", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        mid();
        chk("t2_maddr2", maddr, 32'h202);
        chk("t2_mdata2", mdata, wd(18));
        chk("t2_mwstrb2", mwstrb, 16'h0F0F);
        chk("t2_in_ready_end", in_ready, 0);
        next_cycle();
        mid();
        chk("t2_done", done, 1);
        chk("t2_maddr_end", maddr, 32'h203);
`ifdef XDMA_SEQ_PERF_EN
        chk("t2_perf_beats", perf_beats, 3);
        chk("t2_perf_stall", perf_stall, 2);
`else
        chk("t2_perf_beats_tied", perf_beats, 0);
        chk("t2_perf_stall_tied", perf_stall, 0);
`endif
        next_cycle();
        mid();
        chk("t2_done_pulse", done, 0);
        chk("t2_idle_ready", cmd_ready, 1);

        // ---------------- test 3: mode 3, len 6, backpressure ----------------
        next_cycle();
        cmd_valid = 1'b1; cmd_mode = 4'd3; cmd_addr = 32'h300; cmd_len = 16'd6;
        saccept = 1'b1; svalid = 1'b1; out_ready = 1'b0; sdata = rd(0);
        mid();
        chk("t3_cmd_ready", cmd_ready, 1);
        next_cycle();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sdata = rd(k);
            mid();
            chk("t3_mread", mread, 1);
            chk("t3_mready", mready, 1);
            chk("t3_maddr", maddr, 32'h300 + 32'(k));
            chk("t3_out_valid", out_valid, (k > 0));
            next_cycle();
        end
        sdata = rd(4);
        mid();
        chk("t3_full_mread", mread, 0);
        chk("t3_full_mready", mready, 0);
        chk("t3_full_count", dbg_fifo_count, 4);
        chk("t3_full_head", out_data, rd(0));
        chk("t3_full_maddr", maddr, 32'h304);
        next_cycle();
        out_ready = 1'b1;
        mid();
        chk("t3_full_hold", mread, 0);
        for (int i = 0; i < 6; i++) exp_q.push_back(rd(i));
        sent = 4; got = 0; seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                seen_done = 1'b1;
                chk("t3_empty_at_done", out_valid, 0);
                break;
            end
            if (out_valid) begin
                if (exp_q.size() > 0) chk("t3_out_data", out_data, exp_q.pop_front());
                else                  chk("t3_extra_out", out_valid, 0);
                got++;
            end
            if (mread && saccept && svalid) sent++;
            next_cycle();
            sdata = rd(sent);
            mid();
        end
        chk("t3_seen_done", seen_done, 1);
        chk("t3_out_count", got, 6);
        chk("t3_maddr_end", maddr, 32'h306);
        next_cycle();
        mid();
        chk("t3_idle_ready", cmd_ready, 1);
        chk("t3_idle_busy", busy, 0);

        // ---------------- test 4: bad mode, then zero-length ----------------
        next_cycle();
        out_ready = 1'b0; svalid = 1'b0;
        cmd_valid = 1'b1; cmd_mode = 4'd9; cmd_addr = 32'h500; cmd_len = 16'd5;
        mid();
        chk("t4_cmd_ready", cmd_ready, 1);
        next_cycle();
        cmd_valid = 1'b0;
        mid();
        chk("t4_err_mode", err_mode, 1);
        chk("t4_no_mread", mread, 0);
        chk("t4_no_mwrite", mwrite, 0);
        chk("t4_busy", busy, 0);
        chk("t4_no_done", done, 0);
        chk("t4_ready_back", cmd_ready, 1);
        next_cycle();
        mid();
        chk("t4_err_pulse", err_mode, 0);
        chk("t4_no_done2", done, 0);
        next_cycle();
        cmd_valid = 1'b1; cmd_mode = 4'd2; cmd_addr = 32'h600; cmd_len = 16'd0;
        mid();
        next_cycle();
        cmd_valid = 1'b0;
        mid();
        chk("t4_len0_done", done, 1);
        chk("t4_len0_mwrite", mwrite, 0);
        chk("t4_len0_in_ready", in_ready, 0);
        chk("t4_len0_mode", dma_mode, 2);
        next_cycle();
        mid();
        chk("t4_len0_pulse", done, 0);
        chk("t4_len0_ready", cmd_ready, 1);

        // ---------------- test 5: reset mid-RD, then wrap transfer ----------------
        next_cycle();
        cmd_valid = 1'b1; cmd_mode = 4'd4; cmd_addr = 32'h400; cmd_len = 16'd6;
        saccept = 1'b1; svalid = 1'b1; out_ready = 1'b0; sdata = rd(32);
        mid();
        next_cycle();
        cmd_valid = 1'b0;
        mid();
        chk("t5_mread0", mread, 1);
        next_cycle();
        sdata = rd(33);
        mid();
        chk("t5_mread1", mread, 1);
        next_cycle();
        saccept = 1'b0; xreset = 1'b1;
        mid();
        chk("t5_count2", dbg_fifo_count, 2);
        chk("t5_head", out_data, rd(32));
        chk("t5_busy_pre", busy, 1);
        next_cycle();
        xreset = 1'b0; saccept = 1'b1; svalid = 1'b0;
        mid();
        chk("t5_state_idle", dbg_state, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_done", done, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_count0", dbg_fifo_count, 0);
        next_cycle();
        mid();
        chk("t5_no_late_done", done, 0);

        next_cycle();
        cmd_valid = 1'b1; cmd_mode = 4'd10; cmd_addr = 32'hFFFF_FFFF; cmd_len = 16'd2;
        mid();
        chk("t5b_cmd_ready", cmd_ready, 1);
        next_cycle();
        cmd_valid = 1'b0; in_valid = 1'b1; in_data = wd(40); in_strb = 16'hFFFF;
        mid();
        chk("t5b_in_ready", in_ready, 1);
        chk("t5b_maddr0", maddr, 32'hFFFF_FFFF);
        next_cycle();
        in_data = wd(41);
        mid();
        chk("t5b_mwrite", mwrite, 1);
        chk("t5b_maddr_top", maddr, 32'hFFFF_FFFF);
        chk("t5b_mdata0", mdata, wd(40));
        chk("t5b_in_ready1", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        mid();
        chk("t5b_maddr_wrap", maddr, 32'h0);
        chk("t5b_mdata1", mdata, wd(41));
        chk("t5b_in_ready_end", in_ready, 0);
        next_cycle();
        mid();
        chk("t5b_done", done, 1);
`ifdef XDMA_SEQ_PERF_EN
        chk("t5b_perf_beats", perf_beats, 2);
`endif
        next_cycle();
        mid();
        chk("t5b_done_pulse", done, 0);
        chk("t5b_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
